touch_scan_ctrl: RTL

Memory-mapped controller that sequences the resistive touch-panel ADC (ADS7843-class, SPI mode 0) in response to the panel's pen-interrupt line. On a pen-down falling edge it takes SAMPLES X and SAMPLES Y conversions, averages each axis and latches the results. It then raises a maskable interrupt. It sits on the system interconnect beside the pen-interrupt input, so the CPU no longer bit-bangs the ADC.

---
 rtl/touch_scan_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/touch_scan_ctrl.sv
// touch_scan_ctrl: pen-triggered ADS7843-class SPI scan sequencer with averaging, register map and irq.
// Latency: register reads 1 clk; a scan takes 2*SAMPLES frames of 52*CLK_DIV clk plus a few clk of overhead.
// Backpressure: none; edges while busy are ignored. Define TOUCH_PRESSURE_EN to add Z1/Z2 frames and regs 5/6.
module touch_scan_ctrl #(
  parameter int CLK_DIV = 16,
  parameter int SAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        penirq_n,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int LOG2S = $clog2(SAMPLES);
  localparam int ACC_W = 12 + LOG2S;
  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 2);
  localparam logic [4:0] FRM_LAST = 5'(SAMPLES - 1);
`ifdef TOUCH_PRESSURE_EN
  localparam logic [1:0] LAST_AXIS = 2'd3;
`else
  localparam logic [1:0] LAST_AXIS = 2'd1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP,
    ST_ACC,
    ST_DONE
  } state_t;

  // ADC command byte for each measured axis (12-bit, differential, PD=00)
  function automatic logic [7:0] axis_cmd(input logic [1:0] ax);
    case (ax)
      2'd0:    axis_cmd = 8'hD0;
      2'd1:    axis_cmd = 8'h90;
`ifdef TOUCH_PRESSURE_EN
      2'd2:    axis_cmd = 8'hB0;
      2'd3:    axis_cmd = 8'hC0;
`endif
      default: axis_cmd = 8'h00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              pen_d1_q, pen_d1_d;
  logic              pen_d2_q, pen_d2_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              cont_q, cont_d;
  logic              data_valid_q, data_valid_d;
  logic              overrun_q, overrun_d;
  logic [11:0]       x_q, x_d;
  logic [11:0]       y_q, y_d;
  logic [11:0]       pend_x_q, pend_x_d;
  logic [11:0]       pend_y_q, pend_y_d;
`ifdef TOUCH_PRESSURE_EN
  logic [11:0]       z1_q, z1_d;
  logic [11:0]       z2_q, z2_d;
  logic [11:0]       pend_z1_q, pend_z1_d;
  logic [11:0]       pend_z2_q, pend_z2_d;
`endif
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        frm_q, frm_d;
  logic [1:0]        axis_q, axis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        half_q, half_d;
  logic [15:0]       rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              restart_q, restart_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              pen_down;
  logic              wr_en;
  logic              clr;
  logic              trigger;
  logic              busy;
  logic [11:0]       sample;
  logic [ACC_W-1:0]  acc_sum;
  logic [11:0]       avg;
  logic [5:0]        half_nxt;
  logic [4:0]        bit_idx;
  logic [2:0]        mosi_idx;
  logic [7:0]        cmd_cur;
  logic [7:0]        cmd_start;
  logic              start_frame;
  logic [1:0]        start_axis;
  logic              unused_bits;

  assign pen_down  = ~pen_d2_q;
  assign wr_en     = chipselect & ~write_n;
  assign clr       = wr_en && (address == 3'd4);
  assign busy      = (state_q != ST_IDLE);
  assign trigger   = enable_q & ~pen_d1_q & pen_d2_q & ~busy;
  assign sample    = rx_q[14:3];
  assign acc_sum   = acc_q + ACC_W'(sample);
  assign avg       = acc_sum[ACC_W-1:LOG2S];
  assign half_nxt  = half_q + 6'd1;
  assign bit_idx   = half_q[5:1];
  assign mosi_idx  = 3'd6 - bit_idx[2:0];
  assign cmd_cur   = axis_cmd(axis_q);
  assign cmd_start = axis_cmd(start_axis);

  assign unused_bits = ^{writedata[31:3], rx_q[15], rx_q[2:0], acc_sum, cmd_start, cmd_cur};

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

  // Next-state logic: pen synchronizer, register writes, read mux and the scan sequencer
  always_comb begin
    state_d      = state_q;
    pen_d1_d     = penirq_n;
    pen_d2_d     = pen_d1_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    cont_d       = cont_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    x_d          = x_q;
    y_d          = y_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
`ifdef TOUCH_PRESSURE_EN
    z1_d         = z1_q;
    z2_d         = z2_q;
    pend_z1_d    = pend_z1_q;
    pend_z2_d    = pend_z2_q;
`endif
    acc_d        = acc_q;
    frm_d        = frm_q;
    axis_d       = axis_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    rx_d         = rx_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    restart_d    = restart_q;
    start_frame  = 1'b0;
    start_axis   = 2'd0;

    if (wr_en && (address == 3'd1)) begin
      enable_d = writedata[0];
      irq_en_d = writedata[1];
      cont_d   = writedata[2];
    end
    if (clr) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    irq_d = data_valid_q & irq_en_q;

    case (address)
      3'd0:    readdata_d = {28'd0, overrun_q, data_valid_q, busy, pen_down};
      3'd1:    readdata_d = {29'd0, cont_q, irq_en_q, enable_q};
      3'd2:    readdata_d = {20'd0, x_q};
      3'd3:    readdata_d = {20'd0, y_q};
`ifdef TOUCH_PRESSURE_EN
      3'd5:    readdata_d = {20'd0, z1_q};
      3'd6:    readdata_d = {20'd0, z2_q};
`endif
      default: readdata_d = 32'd0;
    endcase

    case (state_q)
      ST_IDLE: begin
        restart_d = 1'b0;
        if (trigger || restart_q) begin
          start_frame = 1'b1;
          start_axis  = 2'd0;
          axis_d      = 2'd0;
          frm_d       = 5'd0;
          acc_d       = '0;
        end
      end

      // Half 0 is CS setup, halves 1..48 are the 24 SCLK cycles, half 49 is CS hold
      ST_FRAME: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (half_q == 6'd49) begin
            state_d = ST_GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            half_d  = 6'd0;
          end else begin
            half_d = half_nxt;
            if (half_nxt <= 6'd48) begin
              sclk_d = half_nxt[0];
              if (half_nxt[0]) begin
                if (bit_idx >= 5'd8) rx_d = {rx_q[14:0], spi_miso};
              end else begin
                mosi_d = (bit_idx < 5'd7) ? cmd_cur[mosi_idx] : 1'b0;
              end
            end else begin
              sclk_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The last clk of the inter-frame gap is spent in ACC
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_ACC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ACC: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (frm_q == FRM_LAST) begin
          case (axis_q)
            2'd0:    pend_x_d  = avg;
            2'd1:    pend_y_d  = avg;
`ifdef TOUCH_PRESSURE_EN
            2'd2:    pend_z1_d = avg;
            2'd3:    pend_z2_d = avg;
`endif
            default: ;
          endcase
          acc_d = '0;
          frm_d = 5'd0;
          if (axis_q == LAST_AXIS) begin
            state_d = ST_DONE;
          end else begin
            axis_d      = axis_q + 2'd1;
            start_frame = 1'b1;
            start_axis  = axis_q + 2'd1;
          end
        end else begin
          acc_d       = acc_sum;
          frm_d       = frm_q + 5'd1;
          start_frame = 1'b1;
          start_axis  = axis_q;
        end
      end

      // Store only if the pen is still down; a same-cycle CLEAR loses to the store
      ST_DONE: begin
        state_d = ST_IDLE;
        if (pen_down) begin
          x_d          = pend_x_q;
          y_d          = pend_y_q;
`ifdef TOUCH_PRESSURE_EN
          z1_d         = pend_z1_q;
          z2_d         = pend_z2_q;
`endif
          data_valid_d = 1'b1;
          overrun_d    = clr ? 1'b0 : (overrun_q | data_valid_q);
          if (cont_q && enable_q) restart_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d = ST_FRAME;
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = cmd_start[7];
      cnt_d   = '0;
      half_d  = 6'd0;
      rx_d    = 16'd0;
    end
  end

  // State and output registers; reset aborts any scan with SPI lines idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pen_d1_q     <= 1'b0;
      pen_d2_q     <= 1'b0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      cont_q       <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      x_q          <= 12'd0;
      y_q          <= 12'd0;
      pend_x_q     <= 12'd0;
      pend_y_q     <= 12'd0;
`ifdef TOUCH_PRESSURE_EN
      z1_q         <= 12'd0;
      z2_q         <= 12'd0;
      pend_z1_q    <= 12'd0;
      pend_z2_q    <= 12'd0;
`endif
      acc_q        <= '0;
      frm_q        <= 5'd0;
      axis_q       <= 2'd0;
      cnt_q        <= '0;
      half_q       <= 6'd0;
      rx_q         <= 16'd0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      restart_q    <= 1'b0;
      irq_q        <= 1'b0;
      readdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pen_d1_q     <= pen_d1_d;
      pen_d2_q     <= pen_d2_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      cont_q       <= cont_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
`ifdef TOUCH_PRESSURE_EN
      z1_q         <= z1_d;
      z2_q         <= z2_d;
      pend_z1_q    <= pend_z1_d;
      pend_z2_q    <= pend_z2_d;
`endif
      acc_q        <= acc_d;
      frm_q        <= frm_d;
      axis_q       <= axis_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      rx_q         <= rx_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      restart_q    <= restart_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule
